// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_idx_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [1:0]      op_q;
  logic            sgn_diff_q;
  logic            dnd_neg_q;

  logic            is_signed, dnd_neg, dsr_neg, div_zero, ovf, special, accept;
  logic [XLEN-1:0] dnd_abs, dsr_abs, special_res;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    is_signed = ~op_i[0];
    dnd_neg   = is_signed & dividend_i[XLEN-1];
    dsr_neg   = is_signed & divisor_i[XLEN-1];
    dnd_abs   = dnd_neg ? -dividend_i : dividend_i;
    dsr_abs   = dsr_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    // Most-negative / -1 overflows the quotient; RISC-V defines the result directly.
    ovf       = is_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor_i);
    special   = div_zero | ovf;
    if (div_zero)
      special_res = op_i[1] ? dividend_i : '1;
    else
      special_res = op_i[1] ? '0 : dividend_i;
    accept    = (state == IDLE) & start_i & ~kill_i;
  end

  always_comb begin
    rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    rem_ge  = (rem_sh >= {1'b0, dsr_q});
    quo_fix = ((op_q == 2'b00) & sgn_diff_q) ? -quo_q : quo_q;
    rem_fix = ((op_q == 2'b10) & dnd_neg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = special ? DONE : CALC;
      CALC:    if (cnt == '0) state_n = FIXUP;
      FIXUP:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill_i) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      op_q       <= '0;
      sgn_diff_q <= 1'b0;
      dnd_neg_q  <= 1'b0;
      result_o   <= '0;
      rd_idx_o   <= '0;
    end else if (accept) begin
      op_q       <= op_i;
      rd_idx_o   <= rd_idx_i;
      sgn_diff_q <= dnd_neg ^ dsr_neg;
      dnd_neg_q  <= dnd_neg;
      rem_q      <= '0;
      quo_q      <= dnd_abs;
      dsr_q      <= dsr_abs;
      cnt        <= CW'(XLEN-1);
      if (special) result_o <= special_res;
    end else if (state == CALC) begin
      rem_q <= rem_ge ? rem_sub : rem_sh;
      quo_q <= {quo_q[XLEN-2:0], rem_ge};
      cnt   <= cnt - 1'b1;
    end else if (state == FIXUP && !kill_i) begin
      result_o <= op_q[1] ? rem_fix : quo_fix;
    end
  end

  assign stall_o = accept | (state == CALC) | (state == FIXUP);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div against an arithmetic reference model
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_idx_i;
  logic        kill_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_idx_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb_q[$];

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_idx_i(rd_idx_i),
    .kill_i(kill_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_idx_o(rd_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RISC-V M semantics with 64-bit arithmetic so MIN/-1 needs no special handling.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 0) return op[1] ? a : 32'hffff_ffff;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return 32'(ua / ub);
      2'b10:   return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff);
  endfunction

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got done_o=1 expected no pending result");
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("result", {32'd0, result_o}, {32'd0, e[36:5]});
        check("rd_idx", {59'd0, rd_idx_o}, {59'd0, e[4:0]});
      end
    end
  end

  // Called at a negedge; behaves as ID/EX: holds the instruction until stall_o drops.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int st;
    bit s, d, released;
    op_i = op; dividend_i = a; divisor_i = b; rd_idx_i = rd; start_i = 1'b1;
    sb_q.push_back({model(op, a, b), rd});
    st = 0;
    d = 0;
    released = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      s = stall_o;
      d = done_o;
      @(posedge clk);
      if (!s) begin
        released = 1;
        break;
      end
      st++;
      @(negedge clk);
    end
    check("release_timeout", {63'd0, released}, 64'd1);
    check("stall_cycles", 64'(st), is_fast(op, a, b) ? 64'd1 : 64'd34);
    check("done_on_release", {63'd0, d}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    op_i = '0; dividend_i = '0; divisor_i = '0; rd_idx_i = '0;
    @(negedge clk);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_result", {32'd0, result_o}, 64'd0);
    check("rst_rd", {59'd0, rd_idx_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b01, 32'd100, 32'd7, 5'd1);
    issue(2'b11, 32'd100, 32'd7, 5'd2);
    issue(2'b00, 32'hffff_fff9, 32'd2, 5'd3);
    issue(2'b10, 32'hffff_fff9, 32'd2, 5'd4);
    issue(2'b01, 32'd5, 32'd0, 5'd5);
    issue(2'b10, 32'd5, 32'd0, 5'd6);
    issue(2'b00, 32'h8000_0000, 32'hffff_ffff, 5'd7);
    issue(2'b10, 32'h8000_0000, 32'hffff_ffff, 5'd8);
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Kill in the 10th CALC cycle; ID/EX is flushed along with it.
    op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_idx_i = 5'd9; start_i = 1'b1;
    repeat (10) @(negedge clk);
    kill_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    kill_i = 1'b0;
    #1;
    check("kill_stall", {63'd0, stall_o}, 64'd0);
    check("kill_done", {63'd0, done_o}, 64'd0);
    @(negedge clk);
    issue(2'b01, 32'd9, 32'd3, 5'd10);

    issue(2'b00, 32'hffff_ff00, 32'd7, 5'd11);
    issue(2'b11, 32'd12345, 32'd100, 5'd12);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hffff_ffff;
        2:       b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      issue(op, a, b, 5'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        start_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-CALC.
    op_i = 2'b01; dividend_i = 32'hdead_beef; divisor_i = 32'd13; rd_idx_i = 5'd21; start_i = 1'b1;
    repeat (6) @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_stall", {63'd0, stall_o}, 64'd0);
    check("arst_done", {63'd0, done_o}, 64'd0);
    check("arst_result", {32'd0, result_o}, 64'd0);
    check("arst_rd", {59'd0, rd_idx_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_stall", {63'd0, stall_o}, 64'd0);
    repeat (40) @(negedge clk);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
